// File: rtl/dct_quantize.sv
// dct_quantize: row-serial 8x8 quantizer computing out = round(coef * recip / 65536), saturated to 12 bits.
// Ports: clock, reset_n (async, active-low); start launches a block from coef_in[0:63] (row-major);
//        q_we/q_addr/q_data write the reciprocal table while idle; busy marks a block in flight;
//        done pulses for one cycle when out[0:63] is updated, and out holds until the next done.
module dct_quantize (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic signed [11:0] coef_in [0:63],
  input  logic               q_we,
  input  logic        [5:0]  q_addr,
  input  logic        [15:0] q_data,
  output logic               busy,
  output logic               done,
  output logic signed [11:0] out [0:63]
);
  typedef enum logic [1:0] {IDLE, CALC, DRAIN, FLUSH} state_t;
  state_t state;
  logic [2:0] row_cnt, prod_row;
  logic prod_valid;
  logic [7:0] prod_neg;
  logic signed [11:0] snap [0:63];
  logic signed [11:0] res [0:63];
  logic [15:0] recip [0:63];
  logic [27:0] prod [0:7];
  logic [11:0] mag [0:7];
  logic signed [11:0] rounded [0:7];
  for (genvar c = 0; c < 8; c++) begin : g_col
    logic [11:0] a, q;
    always_comb begin
      a = snap[{row_cnt, 3'(c)}];
      mag[c] = a[11] ? ~a + 12'd1 : a;
      q = 12'((prod[c] + 28'd32768) >> 16);
      rounded[c] = prod_neg[c] ? -q : (q[11] ? 12'sd2047 : q);
    end
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      row_cnt <= '0;
      prod_row <= '0;
      prod_valid <= 1'b0;
      prod_neg <= '0;
      for (int i = 0; i < 64; i++) begin
        snap[i] <= '0;
        res[i] <= '0;
        out[i] <= '0;
        recip[i] <= 16'hffff;
      end
      for (int i = 0; i < 8; i++) prod[i] <= '0;
    end else begin
      done <= 1'b0;
      prod_valid <= state == CALC;
      prod_row <= row_cnt;
      if (prod_valid)
        for (int i = 0; i < 8; i++) res[{prod_row, 3'(i)}] <= rounded[i];
      case (state)
        IDLE: begin
          if (q_we) recip[q_addr] <= q_data;
          if (start) begin
            for (int i = 0; i < 64; i++) snap[i] <= coef_in[i];
            row_cnt <= '0;
            busy <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          for (int i = 0; i < 8; i++) begin
            prod[i] <= 28'(mag[i]) * 28'(recip[{row_cnt, 3'(i)}]);
            prod_neg[i] <= snap[{row_cnt, 3'(i)}][11];
          end
          row_cnt <= row_cnt + 3'd1;
          if (row_cnt == 3'd7) state <= DRAIN;
        end
        DRAIN: state <= FLUSH;
        FLUSH: begin
          for (int i = 0; i < 64; i++) out[i] <= res[i];
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_dct_quantize.sv
// tb_dct_quantize: directed-vector bench for dct_quantize with hand-computed expectations.
module tb_dct_quantize;
  logic clock, reset_n, start, q_we, busy, done;
  logic [5:0] q_addr;
  logic [15:0] q_data;
  logic signed [11:0] coef_in [0:63];
  logic signed [11:0] out [0:63];
  int total = 0, bad = 0;
  int lat, bcnt, cnt, first;
  dct_quantize dut (
    .clock(clock), .reset_n(reset_n), .start(start), .coef_in(coef_in),
    .q_we(q_we), .q_addr(q_addr), .q_data(q_data),
    .busy(busy), .done(done), .out(out)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic clear_coef();
    for (int i = 0; i < 64; i++) coef_in[i] = '0;
  endtask
  task automatic count_ne(input int exp, input int skip_lo, input int skip_hi, output int n);
    n = 0;
    for (int i = 0; i < 64; i++)
      if ((i < skip_lo || i > skip_hi) && int'(out[i]) != exp) n++;
  endtask
  task automatic run_block(output int l, output int b);
    tick();
    start = 1'b0;
    q_we = 1'b0;
    b = int'(busy);
    l = -1;
    for (int k = 1; k <= 20 && l < 0; k++) begin
      tick();
      if (busy) b++;
      if (done) l = k;
    end
  endtask
  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    q_we = 1'b0;
    q_addr = '0;
    q_data = '0;
    clear_coef();
    tick();
    tick();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    count_ne(0, 64, 64, cnt);
    check("rst_out_zero", cnt, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 64; i++) coef_in[i] = 12'sd2047;
    start = 1'b1;
    run_block(lat, bcnt);
    check("full_latency", lat, 10);
    check("full_busy_cycles", bcnt, 10);
    count_ne(2047, 64, 64, cnt);
    check("full_out_2047", cnt, 0);
    tick();
    check("done_one_cycle", int'(done), 0);
    clear_coef();
    start = 1'b1;
    tick();
    start = 1'b0;
    q_we = 1'b1;
    q_addr = 6'd5;
    q_data = 16'd0;
    tick();
    tick();
    q_we = 1'b0;
    first = -1;
    for (int k = 3; k <= 20 && first < 0; k++) begin
      tick();
      if (done) first = k;
    end
    check("busy_write_blk_latency", first, 10);
    coef_in[5] = 12'sd500;
    coef_in[6] = -12'sd2048;
    start = 1'b1;
    run_block(lat, bcnt);
    check("busy_write_ignored", int'(out[5]), 500);
    check("neg_sat_full_recip", int'(out[6]), -2048);
    check("busy_write_zero", int'(out[0]), 0);
    for (int i = 0; i < 64; i++) begin
      q_we = 1'b1;
      q_addr = 6'(i);
      q_data = 16'd4096;
      tick();
    end
    q_we = 1'b0;
    clear_coef();
    coef_in[0] = 12'sd1000;
    coef_in[1] = -12'sd1000;
    coef_in[2] = 12'sd7;
    coef_in[3] = -12'sd8;
    coef_in[4] = -12'sd2048;
    start = 1'b1;
    run_block(lat, bcnt);
    check("q16_latency", lat, 10);
    check("q16_out0", int'(out[0]), 63);
    check("q16_out1", int'(out[1]), -63);
    check("q16_out2", int'(out[2]), 0);
    check("q16_out3", int'(out[3]), -1);
    check("q16_out4", int'(out[4]), -128);
    count_ne(0, 0, 4, cnt);
    check("q16_rest_zero", cnt, 0);
    clear_coef();
    coef_in[0] = 12'sd1600;
    start = 1'b1;
    tick();
    check("accept_in_done_cycle", int'(busy), 1);
    start = 1'b0;
    tick();
    tick();
    coef_in[0] = -12'sd1600;
    start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0;
    first = -1;
    for (int k = 4; k <= 24; k++) begin
      tick();
      if (done) begin
        cnt++;
        if (first < 0) first = k;
      end
    end
    check("restart_done_at", first, 10);
    check("restart_done_count", cnt, 1);
    check("snapshot_kept", int'(out[0]), 100);
    check("restart_idle", int'(busy), 0);
    q_we = 1'b1;
    q_addr = 6'd10;
    q_data = 16'd0;
    tick();
    clear_coef();
    coef_in[9] = -12'sd301;
    coef_in[10] = -12'sd2048;
    coef_in[11] = 12'sd2047;
    q_addr = 6'd9;
    q_data = 16'd32768;
    start = 1'b1;
    run_block(lat, bcnt);
    check("same_edge_latency", lat, 10);
    check("same_edge_out9", int'(out[9]), -151);
    check("recip_zero", int'(out[10]), 0);
    check("pos_2047_q16", int'(out[11]), 128);
    check("coef_zero", int'(out[8]), 0);
    clear_coef();
    coef_in[0] = 12'sd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    reset_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    count_ne(0, 64, 64, cnt);
    check("abort_out_zero", cnt, 0);
    tick();
    check("abort_done_t5", int'(done), 0);
    tick();
    check("abort_done_t6", int'(done), 0);
    reset_n = 1'b1;
    coef_in[0] = 12'sd100;
    start = 1'b1;
    run_block(lat, bcnt);
    check("post_rst_latency", lat, 10);
    check("post_rst_table_reset", int'(out[0]), 100);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dct_quantize.md
DCT_QUANTIZE -- requirements
Module: dct_quantize

Interface
REQ-001 Parameters: none; block size fixed at 8x8, coefficient width fixed at signed 12 bits.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request to quantize the current coef_in block; sampled only in IDLE.
REQ-005 coef_in  input  12 x [0:63]  signed 2D DCT coefficients, row-major, index r*8+c.
REQ-006 q_we  input  1  reciprocal-table write enable.
REQ-007 q_addr  input  6  table entry index, row-major, same indexing as coef_in.
REQ-008 q_data  input  16  unsigned reciprocal, round(65536/Q), clipped to 65535 for Q=1.
REQ-009 busy  output  1  high while a block is in flight.
REQ-010 done  output  1  one-cycle pulse; out is valid and updated in the same cycle.
REQ-011 out  output  12 x [0:63]  signed quantized coefficients, row-major, held until the next done.

Function
REQ-012 The FSM SHALL have four states: IDLE, CALC, DRAIN and FLUSH.
REQ-013 In IDLE with start=1, the block SHALL do all of the following at that edge (T0): copy coef_in into an internal snapshot, clear row counter, enter CALC, set busy=1.
REQ-014 In CALC, at edges T1..T8, the block SHALL register 8 products for snapshot row row_cnt and increment row_cnt; after row 7 it enters DRAIN.
REQ-015 Each row's rounded result SHALL be written to an internal result buffer one edge after its product, at edges T2..T9.
REQ-016 DRAIN SHALL last one cycle and write row 7 at T9; FLUSH then follows.
REQ-017 At edge T10 the block SHALL load out from the result buffer, set done=1 for exactly one cycle, clear busy and return to IDLE.
REQ-018 start-to-done latency SHALL be exactly 10 clocks.
REQ-019 Throughput SHALL be one block per 11 clocks; start may be reasserted in the cycle done is high, and is accepted at that edge.
REQ-020 Arithmetic per element: m = |coef| * recip (28-bit unsigned); q = (m + 32768) >> 16; result = -q if coef < 0, else q.
REQ-021 Rounding SHALL be half away from zero, symmetric in sign.
REQ-022 The result SHALL be saturated to -2048..2047 before storage.
REQ-023 start while busy=1 SHALL be ignored, with no queuing; the snapshot SHALL NOT change.
REQ-024 coef_in changes after T0 SHALL NOT affect the block in flight.
REQ-025 A q_we while busy=1 SHALL be ignored.
REQ-026 A q_we in IDLE SHALL write table[q_addr] at that edge.
REQ-027 If q_we and start are both in IDLE on the same edge, the write SHALL take effect, the block SHALL be accepted, and that block SHALL use the updated entry.
REQ-028 coef = 0 SHALL give 0 for any recip, including recip = 0.
REQ-029 recip = 0 SHALL give 0 for any coef.

Reset
REQ-030 On reset_n low, asynchronously: FSM to IDLE, busy=0, done=0, all out entries 0, row counter 0, snapshot, pipeline and result buffer cleared.
REQ-031 On reset, all 64 table entries SHALL be set to 65535 (near-identity quantization).
REQ-032 Reset asserted mid-block SHALL abort the block; no done SHALL be produced for it.
REQ-033 After reset release, the block SHALL accept start on the first clock edge.

Verification
REQ-034 Reset table, coef_in all = 2047, pulse start -> done exactly 10 clocks later; all out = 2047; busy high for exactly 10 cycles.
REQ-035 Write table[0..63] = 4096 (Q=16); coef_in[0]=1000, [1]=-1000, [2]=7, [3]=-8, [4]=-2048, rest 0 -> out[0]=63, out[1]=-63, out[2]=0, out[3]=-1, out[4]=-128, rest 0.
REQ-036 Pulse start, then change coef_in and pulse start again at T3 -> single done at T10 with the original values; second start ignored.
REQ-037 q_we to table[5]=0 while busy -> ignored; the next block with coef_in[5]=500 gives out[5]=500 (table value 65535).
REQ-038 Same-edge q_we (addr 9, data 32768) and start with coef_in[9]=-301 -> out[9]=-151.
REQ-039 reset_n low at T5, released at T7 -> done never asserted; out all 0; busy=0; a new start is accepted normally.
